// File: rtl/mips_alu_decoder_if.sv
// Decoder bus: operation class and funct in, ALU select and invalid flag out.
// The combinational and registered copies of the decode travel together.
interface mips_alu_decoder_if;
  logic [5:0] funct;
  logic [2:0] ALUOp;
  logic [2:0] ALUControl;
  logic [2:0] ALUControl_q;
  logic       invalid;
  logic       invalid_q;

  modport master (
    output funct, ALUOp,
    input  ALUControl, ALUControl_q, invalid, invalid_q
  );

  modport slave (
    input  funct, ALUOp,
    output ALUControl, ALUControl_q, invalid, invalid_q
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// MIPS ALU control decoder: zero-latency decode of ALUOp/funct to an ALU select,
// plus a one-cycle registered copy of the select and the invalid flag.
module mips_alu_decoder (
  input  logic                  clock,
  input  logic                  reset,
  mips_alu_decoder_if.slave     bus
);
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [2:0] w_ctl;
  logic       w_inv;
  logic [2:0] r_ctl_q;
  logic       r_inv_q;

  // Unsupported or unknown inputs fall back to ADD so the datapath stays benign.
  always_comb begin
    w_ctl = ALU_ADD;
    w_inv = 1'b1;
    if (!$isunknown({bus.ALUOp, bus.funct})) begin
      unique case (bus.ALUOp)
        3'b000: begin w_ctl = ALU_ADD; w_inv = 1'b0; end
        3'b001: begin w_ctl = ALU_SUB; w_inv = 1'b0; end
        3'b011: begin w_ctl = ALU_SLT; w_inv = 1'b0; end
        3'b100: begin w_ctl = ALU_SUB; w_inv = 1'b0; end
        3'b110: begin w_ctl = ALU_OR;  w_inv = 1'b0; end
        3'b111: begin w_ctl = ALU_XOR; w_inv = 1'b0; end
        3'b010: begin
          unique case (bus.funct)
            FN_ADD:  begin w_ctl = ALU_ADD; w_inv = 1'b0; end
            FN_SUB:  begin w_ctl = ALU_SUB; w_inv = 1'b0; end
            FN_AND:  begin w_ctl = ALU_AND; w_inv = 1'b0; end
            FN_OR:   begin w_ctl = ALU_OR;  w_inv = 1'b0; end
            FN_XOR:  begin w_ctl = ALU_XOR; w_inv = 1'b0; end
            FN_SLT:  begin w_ctl = ALU_SLT; w_inv = 1'b0; end
            default: begin w_ctl = ALU_ADD; w_inv = 1'b1; end
          endcase
        end
        default: begin w_ctl = ALU_ADD; w_inv = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ctl_q <= ALU_ADD;
      r_inv_q <= 1'b0;
    end else begin
      r_ctl_q <= w_ctl;
      r_inv_q <= w_inv;
    end
  end

  assign bus.ALUControl   = w_ctl;
  assign bus.invalid      = w_inv;
  assign bus.ALUControl_q = r_ctl_q;
  assign bus.invalid_q    = r_inv_q;
endmodule

// File: tb/tb_mips_alu_decoder.sv
// Scoreboard bench for mips_alu_decoder: expectations are queued at drive time
// and popped when the combinational or registered output is sampled.
module tb_mips_alu_decoder;
  typedef struct packed {
    logic [2:0] ctl;
    logic       inv;
  } exp_t;

  logic clock;
  logic reset;
  mips_alu_decoder_if bus ();

  mips_alu_decoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference decode written as lookup tables rather than nested cases.
  function automatic exp_t ref_decode(input logic [2:0] op, input logic [5:0] fn);
    logic [2:0] op_tbl [8];
    logic       op_ok  [8];
    logic [5:0] fn_tbl [6];
    logic [2:0] fn_ctl [6];
    exp_t r;
    op_tbl = '{3'b010, 3'b110, 3'b010, 3'b111, 3'b110, 3'b010, 3'b001, 3'b011};
    op_ok  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    fn_tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a};
    fn_ctl = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b111};
    r.ctl = op_tbl[op];
    r.inv = !op_ok[op];
    if (op == 3'b010) begin
      r.ctl = 3'b010;
      r.inv = 1'b1;
      for (int k = 0; k < 6; k++)
        if (fn == fn_tbl[k]) begin r.ctl = fn_ctl[k]; r.inv = 1'b0; end
    end
    return r;
  endfunction

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    bus.ALUOp = 3'b001;
    bus.funct = 6'b000000;
    @(posedge clock); #1;
    sb.push_back('{ctl: 3'b010, inv: 1'b0});
    e = sb.pop_front(); n_vec++;
    if ({bus.ALUControl_q, bus.invalid_q} !== {e.ctl, e.inv}) begin
      n_err++;
      $display("FAIL reset_q got ctl_q=%b inv_q=%b want %b %b", bus.ALUControl_q, bus.invalid_q, e.ctl, e.inv);
    end
    sb.push_back('{ctl: 3'b110, inv: 1'b0});
    e = sb.pop_front(); n_vec++;
    if ({bus.ALUControl, bus.invalid} !== {e.ctl, e.inv}) begin
      n_err++;
      $display("FAIL reset_comb got ctl=%b inv=%b want %b %b", bus.ALUControl, bus.invalid, e.ctl, e.inv);
    end
    bus.ALUOp = 3'b101;
    @(posedge clock); #1;
    sb.push_back('{ctl: 3'b010, inv: 1'b0});
    e = sb.pop_front(); n_vec++;
    if ({bus.ALUControl_q, bus.invalid_q} !== {e.ctl, e.inv}) begin
      n_err++;
      $display("FAIL reset_hold_q got ctl_q=%b inv_q=%b want %b %b", bus.ALUControl_q, bus.invalid_q, e.ctl, e.inv);
    end
    @(negedge clock);
    reset = 1'b0;
    bus.ALUOp = 3'b001;
    sb.push_back('{ctl: 3'b110, inv: 1'b0});
    @(posedge clock); #1;
    e = sb.pop_front(); n_vec++;
    if ({bus.ALUControl_q, bus.invalid_q} !== {e.ctl, e.inv}) begin
      n_err++;
      $display("FAIL reset_release got ctl_q=%b inv_q=%b want %b %b", bus.ALUControl_q, bus.invalid_q, e.ctl, e.inv);
    end
  endtask

  task automatic test_aluop_sweep();
    logic [2:0] ops [6];
    logic [2:0] ctl [6];
    exp_t e;
    ops = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b110, 3'b111};
    ctl = '{3'b010, 3'b110, 3'b111, 3'b110, 3'b001, 3'b011};
    for (int i = 0; i < 6; i++) begin
      bus.ALUOp = ops[i];
      bus.funct = 6'b101010;
      sb.push_back('{ctl: ctl[i], inv: 1'b0});
      #1;
      e = sb.pop_front(); n_vec++;
      if ({bus.ALUControl, bus.invalid} !== {e.ctl, e.inv}) begin
        n_err++;
        $display("FAIL aluop_sweep op=%b got ctl=%b inv=%b want %b %b", ops[i], bus.ALUControl, bus.invalid, e.ctl, e.inv);
      end
    end
  endtask

  task automatic test_funct_decode();
    logic [5:0] fns [6];
    logic [2:0] ctl [6];
    exp_t e;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010};
    ctl = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b111};
    for (int i = 0; i < 6; i++) begin
      bus.ALUOp = 3'b010;
      bus.funct = fns[i];
      sb.push_back('{ctl: ctl[i], inv: 1'b0});
      #1;
      e = sb.pop_front(); n_vec++;
      if ({bus.ALUControl, bus.invalid} !== {e.ctl, e.inv}) begin
        n_err++;
        $display("FAIL funct_decode fn=%b got ctl=%b inv=%b want %b %b", fns[i], bus.ALUControl, bus.invalid, e.ctl, e.inv);
      end
    end
  endtask

  task automatic test_invalid();
    logic [2:0] ops [5];
    logic [5:0] fns [5];
    exp_t e;
    ops = '{3'b010, 3'b010, 3'b101, 3'b101, 3'b101};
    fns = '{6'b000000, 6'b100001, 6'b100000, 6'b101010, 6'b111111};
    for (int i = 0; i < 5; i++) begin
      bus.ALUOp = ops[i];
      bus.funct = fns[i];
      sb.push_back('{ctl: 3'b010, inv: 1'b1});
      #1;
      e = sb.pop_front(); n_vec++;
      if ({bus.ALUControl, bus.invalid} !== {e.ctl, e.inv}) begin
        n_err++;
        $display("FAIL invalid op=%b fn=%b got ctl=%b inv=%b want %b %b", ops[i], fns[i], bus.ALUControl, bus.invalid, e.ctl, e.inv);
      end
    end
  endtask

  task automatic test_funct_ignored();
    exp_t e;
    bus.ALUOp = 3'b000;
    for (int i = 0; i < 8; i++) begin
      bus.funct = 6'($urandom_range(0, 63));
      sb.push_back('{ctl: 3'b010, inv: 1'b0});
      #1;
      e = sb.pop_front(); n_vec++;
      if ({bus.ALUControl, bus.invalid} !== {e.ctl, e.inv}) begin
        n_err++;
        $display("FAIL funct_ignored fn=%b got ctl=%b inv=%b want %b %b", bus.funct, bus.ALUControl, bus.invalid, e.ctl, e.inv);
      end
    end
  endtask

  task automatic test_registered();
    exp_t e;
    @(negedge clock);
    bus.ALUOp = 3'b000;
    bus.funct = 6'b000000;
    @(posedge clock);
    @(negedge clock);
    bus.ALUOp = 3'b001;
    sb.push_back('{ctl: 3'b010, inv: 1'b0});
    #1;
    e = sb.pop_front(); n_vec++;
    if ({bus.ALUControl_q, bus.invalid_q} !== {e.ctl, e.inv}) begin
      n_err++;
      $display("FAIL reg_before_edge got ctl_q=%b inv_q=%b want %b %b", bus.ALUControl_q, bus.invalid_q, e.ctl, e.inv);
    end
    sb.push_back('{ctl: 3'b110, inv: 1'b0});
    @(posedge clock); #1;
    e = sb.pop_front(); n_vec++;
    if ({bus.ALUControl_q, bus.invalid_q} !== {e.ctl, e.inv}) begin
      n_err++;
      $display("FAIL reg_after_edge got ctl_q=%b inv_q=%b want %b %b", bus.ALUControl_q, bus.invalid_q, e.ctl, e.inv);
    end
    @(negedge clock);
    bus.ALUOp = 3'b101;
    sb.push_back('{ctl: 3'b010, inv: 1'b1});
    @(posedge clock); #1;
    e = sb.pop_front(); n_vec++;
    if ({bus.ALUControl_q, bus.invalid_q} !== {e.ctl, e.inv}) begin
      n_err++;
      $display("FAIL reg_invalid got ctl_q=%b inv_q=%b want %b %b", bus.ALUControl_q, bus.invalid_q, e.ctl, e.inv);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    @(negedge clock);
    bus.ALUOp = 3'b001;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    sb.push_back('{ctl: 3'b010, inv: 1'b0});
    e = sb.pop_front(); n_vec++;
    if ({bus.ALUControl_q, bus.invalid_q} !== {e.ctl, e.inv}) begin
      n_err++;
      $display("FAIL async_reset_q got ctl_q=%b inv_q=%b want %b %b", bus.ALUControl_q, bus.invalid_q, e.ctl, e.inv);
    end
    bus.ALUOp = 3'b011;
    #1;
    sb.push_back('{ctl: 3'b111, inv: 1'b0});
    e = sb.pop_front(); n_vec++;
    if ({bus.ALUControl, bus.invalid} !== {e.ctl, e.inv}) begin
      n_err++;
      $display("FAIL async_reset_comb got ctl=%b inv=%b want %b %b", bus.ALUControl, bus.invalid, e.ctl, e.inv);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] good [6];
    exp_t e;
    good = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a};
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      bus.ALUOp = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) bus.funct = good[$urandom_range(0, 5)];
      else                           bus.funct = 6'($urandom_range(0, 63));
      sb.push_back(ref_decode(bus.ALUOp, bus.funct));
      @(posedge clock); #1;
      e = sb.pop_front(); n_vec++;
      if ({bus.ALUControl_q, bus.invalid_q} !== {e.ctl, e.inv}) begin
        n_err++;
        $display("FAIL back_to_back op=%b fn=%b got ctl_q=%b inv_q=%b want %b %b", bus.ALUOp, bus.funct, bus.ALUControl_q, bus.invalid_q, e.ctl, e.inv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_aluop_sweep();
    test_funct_decode();
    test_invalid();
    test_funct_ignored();
    test_registered();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mips_alu_decoder.md
MIPS_ALU_DECODER -- requirements
Module: mips_alu_decoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all registered state SHALL be cleared immediately on reset assertion, independent of clock.
REQ-002 clock  input  1  rising-edge clock for the registered outputs.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 funct  input  6  R-type function field, instr[5:0].
REQ-005 ALUOp  input  3  operation class from the control FSM.
REQ-006 ALUControl  output  3  combinational ALU operation select.
REQ-007 ALUControl_q  output  3  ALUControl registered on each rising clock edge.
REQ-008 invalid  output  1  combinational flag, high for an unsupported ALUOp or funct.
REQ-009 invalid_q  output  1  invalid registered on each rising clock edge.

Function
REQ-010 ALUControl encoding SHALL be:
- 000 AND
- 001 OR
- 010 ADD
- 011 XOR
- 110 SUB
- 111 SLT
- 100 and 101 are never driven.
REQ-011 ALUControl and invalid SHALL be purely combinational from funct and ALUOp, with zero-cycle latency, so the FSM sees the decode in the same state.
REQ-012 ALUOp decode SHALL be:
- 000 -> ADD (fetch, decode, lw/sw address, addi)
- 001 -> SUB (beq)
- 010 -> funct decode
- 011 -> SLT (slti)
- 100 -> SUB (bne)
- 110 -> OR (ori)
- 111 -> XOR (xori)
REQ-013 funct decode, used only when ALUOp=010, SHALL be:
- 100000 -> ADD
- 100010 -> SUB
- 100100 -> AND
- 100101 -> OR
- 100110 -> XOR
- 101010 -> SLT
REQ-014 ALUOp=010 with any other funct SHALL give ALUControl=010 (ADD) and invalid=1.
REQ-015 ALUOp=101 SHALL give ALUControl=010 (ADD) and invalid=1.
REQ-016 For every ALUOp other than 010, funct SHALL be ignored and SHALL NOT affect either output.
REQ-017 invalid SHALL be 0 for every supported combination listed in REQ-012 and REQ-013.
REQ-018 Any X or Z on an input bit SHALL be treated as unsupported: ALUControl=010, invalid=1.
REQ-019 ALUControl_q and invalid_q SHALL take ALUControl and invalid at each rising clock edge, with one-cycle latency.
REQ-020 The block SHALL contain no other state and no handshake.

Reset
REQ-021 While reset=1, ALUControl_q SHALL be 010 (ADD) and invalid_q SHALL be 0.
REQ-022 Reset SHALL NOT affect the combinational outputs, which SHALL keep decoding during reset.
REQ-023 On the first rising edge after reset deasserts, the registered outputs SHALL capture the current decode.
REQ-024 Reset asserted mid-operation SHALL force the registered outputs to their reset values in the same cycle, with no wait for a clock edge.

Verification
REQ-025 Sweep ALUOp 000, 001, 011, 100, 110, 111 with funct=101010 -> ALUControl = 010, 110, 111, 110, 001, 011 in that order, invalid=0.
REQ-026 ALUOp=010 with funct 100000, 100010, 100100, 100101, 100110, 101010 -> ALUControl = 010, 110, 000, 001, 011, 111, invalid=0.
REQ-027 ALUOp=010 with funct=000000 -> ALUControl=010, invalid=1; ALUOp=101 with any funct -> ALUControl=010, invalid=1.
REQ-028 ALUOp=001 held across one rising edge -> ALUControl_q=110 after the edge; before the edge it holds the previous value.
REQ-029 Assert reset between clock edges while ALUControl_q=110 -> ALUControl_q=010 and invalid_q=0 at once, while ALUControl still follows the inputs.
REQ-030 Change funct while ALUOp=000 -> ALUControl stays 010 and invalid stays 0.
